// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the register file and its clear controller.
package reg_file_pkg;

  // Clear sequencer states.
  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } clr_state_e;

  // Address width for a given register count; never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_file_clear_ctrl.sv
// Clear sequencer: walks an index over every register, one per cycle,
// while Busy is asserted. A Clr seen while already clearing is ignored.
module reg_file_clear_ctrl
  import reg_file_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          Clr,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          last_idx;

  assign last_idx = (32'(idx_q) == 32'(DEPTH - 1));

  // Next-state logic: start on Clr from IDLE, step the index while clearing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (Clr) begin
          state_d = CLEARING;
          idx_d   = '0;
        end
      end
      CLEARING: begin
        if (last_idx) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  // State and index registers, cleared asynchronously so a reset aborts a clear.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign busy    = (state_q == CLEARING);
  assign clr_en  = (state_q == CLEARING);
  assign clr_idx = idx_q;

endmodule

// File: rtl/reg_file.sv
// Register file: one write port, two registered read ports sharing one read
// enable, write-first bypass, optional hard-wired zero register, and a
// sequenced full clear driven by reg_file_clear_ctrl.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int WIDTH    = 64,
  parameter  int DEPTH    = 32,
  parameter  int ZERO_REG = 1,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             WE,
  input  logic [AW-1:0]    WAddr,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             RE,
  input  logic [AW-1:0]    RAddrA,
  input  logic [AW-1:0]    RAddrB,
  output logic [WIDTH-1:0] dataOutA,
  output logic [WIDTH-1:0] dataOutB,
  output logic             RValid,
  input  logic             Clr,
  output logic             Busy
);

  logic             busy;
  logic             clr_en;
  logic [AW-1:0]    clr_idx;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic [WIDTH-1:0] dout_a_q, dout_a_d;
  logic [WIDTH-1:0] dout_b_q, dout_b_d;
  logic             rvalid_q, rvalid_d;

  logic             wr_ok;
  logic             rd_ok;
  logic             ra_zero;
  logic             rb_zero;

  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  reg_file_clear_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_ctrl (
    .Clk     (Clk),
    .Rst     (Rst),
    .Clr     (Clr),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  // A pending or running clear blocks every access; bad or read-only
  // addresses drop the write, and reads of them return zero.
  assign wr_ok   = WE && !busy && !Clr && addr_in_range(WAddr) && !is_zero_reg(WAddr);
  assign rd_ok   = RE && !busy && !Clr;
  assign ra_zero = !addr_in_range(RAddrA) || is_zero_reg(RAddrA);
  assign rb_zero = !addr_in_range(RAddrB) || is_zero_reg(RAddrB);

  // Storage next state: the clear sequencer owns the array while it runs.
  always_comb begin
    mem_d = mem_q;
    if (clr_en) begin
      mem_d[clr_idx] = '0;
    end else if (wr_ok) begin
      mem_d[WAddr] = dataIn;
    end
  end

  // Read path: load both ports on an accepted read, forwarding a same-cycle write.
  always_comb begin
    dout_a_d = dout_a_q;
    dout_b_d = dout_b_q;
    rvalid_d = 1'b0;
    if (rd_ok) begin
      rvalid_d = 1'b1;
      if (ra_zero)                       dout_a_d = '0;
      else if (wr_ok && WAddr == RAddrA) dout_a_d = dataIn;
      else                               dout_a_d = mem_q[RAddrA];
      if (rb_zero)                       dout_b_d = '0;
      else if (wr_ok && WAddr == RAddrB) dout_b_d = dataIn;
      else                               dout_b_d = mem_q[RAddrB];
    end
  end

  // Storage and read-port registers, all cleared by the asynchronous reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dout_a_q <= '0;
      dout_b_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign dataOutA = dout_a_q;
  assign dataOutB = dout_b_q;
  assign RValid   = rvalid_q;
  assign Busy     = busy;

endmodule
